// File: rtl/mt6835_pkg.sv
// mt6835_pkg: shared frame constants and FSM encoding for the MT6835 reader/responder pair
package mt6835_pkg;
  localparam logic [3:0]  CMD_READ   = 4'hA;
  localparam logic [11:0] ADDR_ANGLE = 12'h003;
  localparam logic [7:0]  CRC_POLY   = 8'h07;
  localparam logic [7:0]  CRC_INIT   = 8'h00;
  localparam int CMD_W    = 16;
  localparam int RESP_W   = 32;
  localparam int ANGLE_W  = 21;
  localparam int STATUS_W = 3;
  localparam int SNAP_W   = ANGLE_W + STATUS_W;
  localparam int FRAME_W  = CMD_W + RESP_W;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_RESP, ST_IGNORE, ST_DONE} state_t;
endpackage

// File: rtl/mt6835_spi_responder_if.sv
// mt6835_spi_responder_if: SPI pin bundle between master and responder
interface mt6835_spi_responder_if;
  logic spi_clk;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;
  modport master(output spi_clk, spi_cs, spi_mosi, input spi_miso, spi_miso_oe);
  modport slave(input spi_clk, spi_cs, spi_mosi, output spi_miso, spi_miso_oe);
endinterface

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial MSB-first CRC-8, non-reflected, no final XOR
module crc8_serial
  import mt6835_pkg::*;
#(
  parameter logic [7:0] POLY = CRC_POLY,
  parameter logic [7:0] INIT = CRC_INIT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       seed,
  input  logic       en,
  input  logic       data_bit,
  output logic [7:0] crc
);
  // reseed at frame start, then fold in one data bit per enabled cycle
  always_ff @(posedge i_clk)
    if (i_rst || seed) crc <= INIT;
    else if (en) crc <= {crc[6:0], 1'b0} ^ ((crc[7] ^ data_bit) ? POLY : 8'h00);
endmodule

// File: rtl/mt6835_spi_responder.sv
// mt6835_spi_responder: sensor-side MT6835 angle-read SPI emulator (mode 3, oversampled pins)
module mt6835_spi_responder
  import mt6835_pkg::*;
#(
  parameter logic [3:0]  CMD_READ_P   = CMD_READ,
  parameter logic [11:0] ADDR_ANGLE_P = ADDR_ANGLE,
  parameter logic [7:0]  CRC_POLY_P   = CRC_POLY,
  parameter logic [7:0]  CRC_INIT_P   = CRC_INIT,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mt6835_spi_responder_if.slave spi,
  input  logic [ANGLE_W-1:0]  i_angle,
  input  logic [STATUS_W-1:0] i_status,
  output logic                o_busy,
  output logic                o_cmd_valid,
  output logic [CMD_W-1:0]    o_cmd,
  output logic                o_frame_done,
  output logic                o_frame_err
);
  localparam logic [CMD_W-1:0] READ_WORD = {CMD_READ_P, ADDR_ANGLE_P};
  logic [SYNC_STAGES-1:0] sck_s, cs_s, mosi_s;
  logic sck_q, cs_q, armed;
  logic sck, cs, mosi, sck_rise, sck_fall, cs_rise, cs_fall, cmd_last, resp_last;
  state_t state_q, state_d;
  logic [5:0] bit_cnt;
  logic [4:0] crc_cnt;
  logic [CMD_W-2:0] cmd_sr;
  logic [CMD_W-1:0] cmd_word;
  logic [SNAP_W-1:0] snap, crc_sr;
  logic [RESP_W-1:0] resp_sr;
  logic [7:0] crc;
  logic miso_q;
  assign sck = sck_s[SYNC_STAGES-1];
  assign cs = cs_s[SYNC_STAGES-1];
  assign mosi = mosi_s[SYNC_STAGES-1];
  assign sck_rise = sck & ~sck_q;
  assign sck_fall = ~sck & sck_q;
  assign cs_rise = cs & ~cs_q;
  // a CS fall only counts once CS has been seen high since reset
  assign cs_fall = armed & cs_q & ~cs;
  assign cmd_word = {cmd_sr, mosi};
  assign cmd_last = state_q == ST_CMD && sck_rise && bit_cnt == 6'(CMD_W - 1) && !cs_rise;
  assign resp_last = state_q == ST_RESP && sck_rise && bit_cnt == 6'(FRAME_W - 1) && !cs_rise;
  assign o_busy = state_q != ST_IDLE;
  assign spi.spi_miso = miso_q;
  assign spi.spi_miso_oe = state_q == ST_RESP;
  // pin synchronisers plus one history flop for edge detection; CS resets low so arming waits for a real high
  always_ff @(posedge i_clk)
    if (i_rst) begin
      sck_s <= '1;
      cs_s <= '0;
      mosi_s <= '0;
      sck_q <= 1'b1;
      cs_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      sck_s <= {sck_s[SYNC_STAGES-2:0], spi.spi_clk};
      cs_s <= {cs_s[SYNC_STAGES-2:0], spi.spi_cs};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi.spi_mosi};
      sck_q <= sck;
      cs_q <= cs;
      armed <= armed | cs;
    end
  // FSM state register
  always_ff @(posedge i_clk)
    if (i_rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  // FSM next state; CS rise overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = cs_fall ? ST_CMD : ST_IDLE;
      ST_CMD:  state_d = cmd_last ? (cmd_word == READ_WORD ? ST_RESP : ST_IGNORE) : ST_CMD;
      ST_RESP: state_d = resp_last ? ST_DONE : ST_RESP;
      default: state_d = state_q;
    endcase
    if (cs_rise) state_d = ST_IDLE;
  end
  // frame datapath: snapshot, command shift, response shift and status pulses
  always_ff @(posedge i_clk)
    if (i_rst) begin
      bit_cnt <= '0;
      crc_cnt <= '0;
      cmd_sr <= '0;
      snap <= '0;
      crc_sr <= '0;
      resp_sr <= '0;
      miso_q <= 1'b1;
      o_cmd <= '0;
      o_cmd_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_cmd_valid <= cmd_last;
      o_frame_done <= resp_last;
      o_frame_err <= cs_rise && (state_q == ST_CMD || state_q == ST_RESP);
      crc_cnt <= crc_cnt != 0 ? crc_cnt - 5'd1 : crc_cnt;
      crc_sr <= crc_sr << 1;
      if (cs_rise) miso_q <= 1'b1;
      if (state_q == ST_IDLE && cs_fall) begin
        snap <= {i_angle, i_status};
        crc_sr <= {i_angle, i_status};
        crc_cnt <= 5'(SNAP_W);
        bit_cnt <= '0;
      end
      if ((state_q == ST_CMD || state_q == ST_RESP) && sck_rise && !cs_rise) bit_cnt <= bit_cnt + 6'd1;
      if (state_q == ST_CMD && sck_rise && !cs_rise) cmd_sr <= cmd_word[CMD_W-2:0];
      if (cmd_last) begin
        o_cmd <= cmd_word;
        resp_sr <= {snap, crc};
      end
      if (state_q == ST_RESP && sck_fall && !cs_rise) begin
        miso_q <= resp_sr[RESP_W-1];
        resp_sr <= resp_sr << 1;
      end
    end
  crc8_serial #(.POLY(CRC_POLY_P), .INIT(CRC_INIT_P)) u_crc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .seed     (state_q == ST_IDLE && cs_fall),
    .en       (crc_cnt != 0),
    .data_bit (crc_sr[SNAP_W-1]),
    .crc      (crc)
  );
endmodule

// File: tb/tb_mt6835_spi_responder.sv
// tb_mt6835_spi_responder: directed vector bench for the MT6835 SPI responder
module tb_mt6835_spi_responder;
  localparam int HALF = 8;
  typedef struct {
    logic [20:0] angle;
    logic [2:0]  status;
    logic [15:0] cmd;
    logic [31:0] resp;
    logic        is_read;
  } vec_t;
  logic clk, rst;
  logic [20:0] angle;
  logic [2:0] status;
  logic busy, cmd_valid, frame_done, frame_err;
  logic [15:0] o_cmd;
  int n_chk, n_fail, n_cv, n_done, n_err, n_oe;
  mt6835_spi_responder_if spi();
  mt6835_spi_responder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .spi          (spi),
    .i_angle      (angle),
    .i_status     (status),
    .o_busy       (busy),
    .o_cmd_valid  (cmd_valid),
    .o_cmd        (o_cmd),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (cmd_valid) n_cv++;
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (spi.spi_miso_oe) n_oe++;
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic sck_bit(input logic m, output logic s);
    spi.spi_clk = 1'b0;
    spi.spi_mosi = m;
    wait_clk(HALF);
    s = spi.spi_miso;
    spi.spi_clk = 1'b1;
    wait_clk(HALF);
  endtask
  task automatic run_frame(input logic [15:0] cmd, input int nbits, input int chg_bit,
                           input logic [20:0] chg_angle, output logic [31:0] rx);
    logic s;
    rx = '0;
    spi.spi_cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) angle = chg_angle;
      sck_bit(i < 16 ? cmd[15-i] : 1'b0, s);
      if (i >= 16) rx = {rx[30:0], s};
    end
    spi.spi_cs = 1'b1;
    wait_clk(2 * HALF);
  endtask
  initial begin
    vec_t vec[7];
    logic [31:0] rx;
    logic [15:0] rd;
    logic s;
    int b_cv, b_done, b_err, b_oe;
    vec[0] = '{21'h000000, 3'h0, 16'hA003, 32'h00000000, 1'b1};
    vec[1] = '{21'h000001, 3'h0, 16'hA003, 32'h00000838, 1'b1};
    vec[2] = '{21'h000000, 3'h7, 16'hA003, 32'h00000715, 1'b1};
    vec[3] = '{21'h1FFFFF, 3'h7, 16'hA003, 32'hFFFFFF0F, 1'b1};
    vec[4] = '{21'h100000, 3'h0, 16'hA003, 32'h8000000B, 1'b1};
    vec[5] = '{21'h000001, 3'h0, 16'h3003, 32'h0, 1'b0};
    vec[6] = '{21'h000001, 3'h0, 16'hA004, 32'h0, 1'b0};
    n_chk = 0; n_fail = 0; n_cv = 0; n_done = 0; n_err = 0; n_oe = 0;
    rd = 16'hA003;
    rst = 1'b1;
    spi.spi_cs = 1'b1; spi.spi_clk = 1'b1; spi.spi_mosi = 1'b0;
    angle = '0; status = '0;
    wait_clk(5);
    check("rst miso", 32'(spi.spi_miso), 32'h1);
    check("rst oe", 32'(spi.spi_miso_oe), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst cmd", 32'(o_cmd), 32'h0);
    check("rst pulses", {29'h0, cmd_valid, frame_done, frame_err}, 32'h0);
    rst = 1'b0;
    wait_clk(2 * HALF);
    for (int k = 0; k < 7; k++) begin
      angle = vec[k].angle;
      status = vec[k].status;
      b_cv = n_cv; b_done = n_done; b_err = n_err; b_oe = n_oe;
      run_frame(vec[k].cmd, 48, -1, '0, rx);
      check($sformatf("v%0d cmd_valid", k), 32'(n_cv - b_cv), 32'd1);
      check($sformatf("v%0d o_cmd", k), 32'(o_cmd), 32'(vec[k].cmd));
      check($sformatf("v%0d done", k), 32'(n_done - b_done), 32'(vec[k].is_read));
      check($sformatf("v%0d err", k), 32'(n_err - b_err), 32'd0);
      check($sformatf("v%0d oe_seen", k), 32'(n_oe > b_oe), 32'(vec[k].is_read));
      if (vec[k].is_read) check($sformatf("v%0d resp", k), rx, vec[k].resp);
      check($sformatf("v%0d busy_after", k), 32'(busy), 32'h0);
    end
    angle = 21'h000001; status = '0;
    b_done = n_done; b_err = n_err;
    run_frame(16'hA003, 20, -1, '0, rx);
    check("abort err", 32'(n_err - b_err), 32'd1);
    check("abort done", 32'(n_done - b_done), 32'd0);
    check("abort busy", 32'(busy), 32'h0);
    check("abort miso", 32'(spi.spi_miso), 32'h1);
    run_frame(16'hA003, 48, -1, '0, rx);
    check("post abort resp", rx, 32'h00000838);
    angle = 21'h0AAAAA;
    run_frame(16'hA003, 48, 10, 21'h155555, rx);
    check("snapshot resp", rx, 32'h5555501E);
    angle = 21'h000001;
    b_err = n_err;
    spi.spi_cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 24; i++) sck_bit(i < 16 ? rd[15-i] : 1'b0, s);
    check("pre rst oe", 32'(spi.spi_miso_oe), 32'h1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("mid rst oe", 32'(spi.spi_miso_oe), 32'h0);
    check("mid rst miso", 32'(spi.spi_miso), 32'h1);
    check("mid rst busy", 32'(busy), 32'h0);
    check("mid rst cmd", 32'(o_cmd), 32'h0);
    for (int i = 0; i < 4; i++) sck_bit(1'b0, s);
    check("rst idle busy", 32'(busy), 32'h0);
    check("rst no err", 32'(n_err - b_err), 32'd0);
    spi.spi_cs = 1'b1;
    wait_clk(2 * HALF);
    run_frame(16'hA003, 48, -1, '0, rx);
    check("post rst resp", rx, 32'h00000838);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
